// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare, auto-reload and one-shot modes.
// Optional interrupt output enabled by defining MMIO_TIMER_IRQ_EN.
module mmio_timer #(
   parameter logic [8:0] BASE_ADDR = 9'h140,
   parameter int         CNT_W     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mem_cmd,
   input  logic [8:0]  mem_addr,
   input  logic [15:0] write_data,
   output logic [15:0] read_data,
   output logic        rd_en,
   output logic        irq
);

   localparam logic [1:0] M_READ  = 2'b01;
   localparam logic [1:0] M_WRITE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   state_t           state;
   logic             en, auto_reload, one_shot, ie;
   logic [CNT_W-1:0] count, compare, count_inc;
   logic [2:0]       status;
   logic [7:0]       prescale, pcnt;
   logic             reload_pend;

   logic       hit, wr;
   logic [2:0] offset, w1c, flag_set;
   logic       wr_ctrl, wr_count, wr_compare, wr_status, wr_presc;
   logic       tick, tick_cnt, match_hit, ovf_hit;

   assign hit    = (mem_addr[8:3] == BASE_ADDR[8:3]);
   assign offset = mem_addr[2:0];
   assign wr     = hit && (mem_cmd == M_WRITE);
   assign rd_en  = hit && (mem_cmd == M_READ) && !reset;

   assign wr_ctrl    = wr && (offset == 3'd0);
   assign wr_count   = wr && (offset == 3'd1);
   assign wr_compare = wr && (offset == 3'd2);
   assign wr_status  = wr && (offset == 3'd3);
   assign wr_presc   = wr && (offset == 3'd4);

   // A pending reload consumes its tick, so it never raises MATCH/OVF.
   assign tick      = (state == RUN) && (pcnt >= prescale);
   assign tick_cnt  = tick && !wr_count && !reload_pend;
   assign count_inc = count + CNT_W'(1);
   assign match_hit = tick_cnt && (count_inc == compare);
   assign ovf_hit   = tick_cnt && (count_inc == '0);

   assign w1c      = wr_status ? write_data[2:0] : 3'b000;
   assign flag_set = {match_hit && one_shot, ovf_hit, match_hit};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         en          <= 1'b0;
         auto_reload <= 1'b0;
         one_shot    <= 1'b0;
         count       <= '0;
         compare     <= '0;
         status      <= 3'b000;
         prescale    <= 8'h00;
         pcnt        <= 8'h00;
         reload_pend <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en          <= write_data[0];
            auto_reload <= write_data[1];
            one_shot    <= write_data[2];
         end
         if (wr_compare) compare <= write_data[CNT_W-1:0];
         if (wr_presc) prescale <= write_data[7:0];

         if (wr_count) pcnt <= 8'h00;
         else if (state == RUN) pcnt <= tick ? 8'h00 : pcnt + 8'd1;

         if (wr_count) begin
            count       <= write_data[CNT_W-1:0];
            reload_pend <= 1'b0;
         end else if (tick) begin
            if (reload_pend) begin
               count       <= '0;
               reload_pend <= 1'b0;
            end else begin
               count <= count_inc;
               if (match_hit && auto_reload && !one_shot)
                  reload_pend <= 1'b1;
            end
         end

         status <= (status & ~w1c) | flag_set;

         case (state)
            IDLE: if (wr_ctrl && write_data[0]) state <= RUN;
            RUN: begin
               if (wr_ctrl && !write_data[0]) state <= IDLE;
               else if (match_hit && one_shot) state <= HALT;
            end
            HALT: if (wr_ctrl) state <= write_data[0] ? RUN : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MMIO_TIMER_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ie  <= 1'b0;
         irq <= 1'b0;
      end else begin
         if (wr_ctrl) ie <= write_data[3];
         irq <= ie & (status[0] | status[1]);
      end
   end
`else
   assign ie  = 1'b0;
   assign irq = 1'b0;
`endif

   always_comb begin
      read_data = 16'h0000;
      if (rd_en) begin
         case (offset)
            3'd0:    read_data = {12'h000, ie, one_shot, auto_reload, en};
            3'd1:    read_data = 16'(count);
            3'd2:    read_data = 16'(compare);
            3'd3:    read_data = {10'h000, state, 1'b0, status};
            3'd4:    read_data = {8'h00, prescale};
            default: read_data = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: reads push expected bus values,
// a negedge monitor pops and compares them against rd_en/read_data/irq.
module tb_mmio_timer;

   localparam logic [1:0] M_NONE  = 2'b00;
   localparam logic [1:0] M_READ  = 2'b01;
   localparam logic [1:0] M_WRITE = 2'b10;
`ifdef MMIO_TIMER_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] write_data;
   logic [15:0] read_data;
   logic        rd_en;
   logic        irq;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string       name;
      logic        en;
      logic [15:0] data;
      logic        irq;
   } exp_t;

   exp_t sb[$];

   mmio_timer dut (
      .clk        (clk),
      .reset      (reset),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .write_data (write_data),
      .read_data  (read_data),
      .rd_en      (rd_en),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_cmd == M_READ) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: read with no expected entry");
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({rd_en, read_data, irq} !== {e.en, e.data, e.irq}) begin
               miscompares++;
               $display("FAIL %s: got en=%0b data=%h irq=%0b, want en=%0b data=%h irq=%0b",
                        e.name, rd_en, read_data, irq, e.en, e.data, e.irq);
            end
         end
      end
   end

   task automatic raw(input logic [1:0] c, input logic [8:0] a,
                      input logic [15:0] d);
      mem_cmd    = c;
      mem_addr   = a;
      write_data = d;
      @(posedge clk);
      #1;
      mem_cmd = M_NONE;
   endtask

   task automatic wr(input logic [2:0] off, input logic [15:0] d);
      raw(M_WRITE, {6'b101000, off}, d);
   endtask

   task automatic rd(input logic [8:0] a, input logic en,
                     input logic [15:0] d, input logic i, input string n);
      exp_t e;
      e.name = n;
      e.en   = en;
      e.data = d;
      e.irq  = i;
      sb.push_back(e);
      raw(M_READ, a, 16'h0000);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      mem_cmd    = M_NONE;
      mem_addr   = 9'h000;
      write_data = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      rd(9'h140, 1'b1, 16'h0000, 1'b0, "rst_ctrl");
      rd(9'h141, 1'b1, 16'h0000, 1'b0, "rst_count");
      rd(9'h143, 1'b1, 16'h0000, 1'b0, "rst_status");

      // prescale 3: ticks at edges 4,8,..,20 after the enabling write
      wr(3'd4, 16'h0003);
      wr(3'd0, 16'h0001);
      idle(19);
      rd(9'h141, 1'b1, 16'h0004, 1'b0, "presc_19clk");
      rd(9'h141, 1'b1, 16'h0005, 1'b0, "presc_20clk");
      wr(3'd0, 16'h0000);

      // auto reload: 0,1,2,3,4,0,1
      wr(3'd4, 16'h0000);
      wr(3'd1, 16'h0000);
      wr(3'd2, 16'h0004);
      wr(3'd0, 16'h0003);
      rd(9'h141, 1'b1, 16'h0000, 1'b0, "reload_c0");
      rd(9'h141, 1'b1, 16'h0001, 1'b0, "reload_c1");
      rd(9'h141, 1'b1, 16'h0002, 1'b0, "reload_c2");
      rd(9'h141, 1'b1, 16'h0003, 1'b0, "reload_c3");
      rd(9'h141, 1'b1, 16'h0004, 1'b0, "reload_c4");
      rd(9'h141, 1'b1, 16'h0000, 1'b0, "reload_c0b");
      rd(9'h141, 1'b1, 16'h0001, 1'b0, "reload_c1b");
      rd(9'h143, 1'b1, 16'h0011, 1'b0, "reload_status");
      wr(3'd0, 16'h0000);
      wr(3'd3, 16'h0007);

      // one-shot to HALT
      wr(3'd1, 16'h0000);
      wr(3'd2, 16'h0002);
      wr(3'd0, 16'h0005);
      idle(3);
      rd(9'h141, 1'b1, 16'h0002, 1'b0, "oneshot_count");
      rd(9'h143, 1'b1, 16'h0025, 1'b0, "oneshot_status");
      wr(3'd3, 16'h0005);
      rd(9'h143, 1'b1, 16'h0020, 1'b0, "oneshot_w1c");
      wr(3'd0, 16'h0000);

      // races with prescale 0
      wr(3'd1, 16'h0000);
      wr(3'd2, 16'h8000);
      wr(3'd0, 16'h0001);
      wr(3'd1, 16'h00FF);
      rd(9'h141, 1'b1, 16'h00FF, 1'b0, "race_count_wr");
      wr(3'd1, 16'hFFFF);
      wr(3'd3, 16'h0002);
      rd(9'h143, 1'b1, 16'h0012, 1'b0, "race_ovf_w1c");
      wr(3'd0, 16'h0000);
      wr(3'd3, 16'h0007);
      rd(9'h143, 1'b1, 16'h0000, 1'b0, "ovf_cleared");

      // decode and bus behaviour
      wr(3'd1, 16'h0ABC);
      rd(9'h0C1, 1'b0, 16'h0000, 1'b0, "miss_rd_en");
      rd(9'h146, 1'b1, 16'h0000, 1'b0, "unused_off6");
      rd(9'h141, 1'b1, 16'h0ABC, 1'b0, "count_read");
      raw(2'b11, 9'h141, 16'h1234);
      raw(M_WRITE, 9'h0C1, 16'h5555);
      rd(9'h141, 1'b1, 16'h0ABC, 1'b0, "no_write_cmd11_miss");
      wr(3'd4, 16'h01FF);
      rd(9'h144, 1'b1, 16'h00FF, 1'b0, "presc_8bit");
      wr(3'd7, 16'hFFFF);
      rd(9'h147, 1'b1, 16'h0000, 1'b0, "unused_off7");
      wr(3'd0, 16'hFFFE);
      rd(9'h140, 1'b1, IRQ_ON ? 16'h000E : 16'h0006, 1'b0, "ctrl_bits");
      wr(3'd0, 16'h0000);

      // irq: match at 3rd tick, irq one clock later, clears one clock after W1C
      wr(3'd4, 16'h0000);
      wr(3'd1, 16'h0000);
      wr(3'd2, 16'h0003);
      wr(3'd0, 16'h000B);
      idle(2);
      rd(9'h143, 1'b1, 16'h0010, 1'b0, "irq_pre");
      rd(9'h143, 1'b1, 16'h0011, 1'b0, "irq_match_edge");
      rd(9'h143, 1'b1, 16'h0011, IRQ_ON, "irq_asserted");
      wr(3'd0, 16'h0008);
      wr(3'd3, 16'h0001);
      rd(9'h143, 1'b1, 16'h0000, IRQ_ON, "irq_w1c_edge");
      rd(9'h143, 1'b1, 16'h0000, 1'b0, "irq_deasserted");

      // asynchronous reset mid-run at COUNT=0x0123
      wr(3'd0, 16'h0000);
      wr(3'd2, 16'h8000);
      wr(3'd1, 16'h0121);
      wr(3'd0, 16'h0001);
      idle(2);
      reset = 1'b1;
      rd(9'h141, 1'b0, 16'h0000, 1'b0, "reset_outputs");
      reset = 1'b0;
      rd(9'h140, 1'b1, 16'h0000, 1'b0, "post_rst_ctrl");
      rd(9'h141, 1'b1, 16'h0000, 1'b0, "post_rst_count");
      rd(9'h143, 1'b1, 16'h0000, 1'b0, "post_rst_status");

      idle(2);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
